// File: rtl/polyvec_use_hint_ctrl.sv
// Purpose : decodes the packed signature hint field into per-polynomial 256-bit masks,
//           runs each w'approx polynomial through the use_hint datapath and writes w1 back.
// Latency : 1 + sum_k(5 + 2*n_k) + 2*(OMEGA - total) + 2 cycles from start to done (error-free).
// Backpressure: none; memories answer in a fixed 1 cycle, start is ignored while busy.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start/busy/done/err control handshake with the verify FSM (err valid with done)
//   hb_addr/hb_rd/hb_data  hint byte buffer read port (1-cycle latency)
//   pr_addr/pr_rd/pr_data  polynomial RAM read port (1-cycle latency)
//   pw_addr/pw_en/pw_data  polynomial RAM write port
//   ud_a/ud_h/ud_b      combinational poly_use_hint datapath interface
module polyvec_use_hint_ctrl #(
  parameter int K     = 4,
  parameter int OMEGA = 80,
  parameter int PA_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        hb_addr,
  output logic              hb_rd,
  input  logic [7:0]        hb_data,
  output logic [PA_W-1:0]   pr_addr,
  output logic              pr_rd,
  input  logic [8191:0]     pr_data,
  output logic [PA_W-1:0]   pw_addr,
  output logic              pw_en,
  output logic [8191:0]     pw_data,
  output logic [8191:0]     ud_a,
  output logic [255:0]      ud_h,
  input  logic [8191:0]     ud_b
);

  localparam logic [7:0] OMEGA_B = 8'(OMEGA);
  localparam logic [3:0] K_B     = 4'(K);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CNT, S_WT_CNT, S_RD_IDX, S_WT_IDX,
    S_RD_POLY, S_WT_POLY, S_WR_POLY, S_RD_PAD, S_WT_PAD,
    S_FIN, S_ABORT
  } state_t;

  state_t       state;
  logic [3:0]   k;
  logic [7:0]   j;
  logic [7:0]   cnt_end;
  logic [7:0]   prev_end;
  logic [7:0]   prev_idx;
  logic [255:0] mask;

  logic [7:0]   j_inc;
  logic [3:0]   k_inc;

  assign j_inc = j + 8'd1;
  assign k_inc = k + 4'd1;

  // Read strobes are raised on the transition INTO an issue state, so the
  // strobe is high during the issue cycle, the memory captures it at the end
  // of that cycle and the data is stable for the whole following wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      hb_addr  <= '0;
      hb_rd    <= 1'b0;
      pr_addr  <= '0;
      pr_rd    <= 1'b0;
      pw_addr  <= '0;
      pw_en    <= 1'b0;
      pw_data  <= '0;
      ud_a     <= '0;
      ud_h     <= '0;
      k        <= '0;
      j        <= '0;
      cnt_end  <= '0;
      prev_end <= '0;
      prev_idx <= '0;
      mask     <= '0;
    end else begin
      done  <= 1'b0;
      hb_rd <= 1'b0;
      pr_rd <= 1'b0;
      pw_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            busy     <= 1'b1;
            k        <= '0;
            prev_end <= '0;
            hb_addr  <= OMEGA_B;
            hb_rd    <= 1'b1;
            state    <= S_RD_CNT;
          end
        end
        S_RD_CNT: state <= S_WT_CNT;
        S_WT_CNT: begin
          // Cumulative counts must be non-decreasing and never exceed OMEGA.
          if (hb_data < prev_end || hb_data > OMEGA_B) begin
            state <= S_ABORT;
          end else begin
            cnt_end <= hb_data;
            mask    <= '0;
            j       <= prev_end;
            if (prev_end < hb_data) begin
              hb_addr <= prev_end;
              hb_rd   <= 1'b1;
              state   <= S_RD_IDX;
            end else begin
              pr_addr <= PA_W'(k);
              pr_rd   <= 1'b1;
              state   <= S_RD_POLY;
            end
          end
        end
        S_RD_IDX: state <= S_WT_IDX;
        S_WT_IDX: begin
          // Strictly increasing within a polynomial; the first index of each
          // polynomial (j == prev_end) is not compared with the previous one.
          if (j > prev_end && hb_data <= prev_idx) begin
            state <= S_ABORT;
          end else begin
            mask[hb_data] <= 1'b1;
            prev_idx      <= hb_data;
            j             <= j_inc;
            if (j_inc < cnt_end) begin
              hb_addr <= j_inc;
              hb_rd   <= 1'b1;
              state   <= S_RD_IDX;
            end else begin
              pr_addr <= PA_W'(k);
              pr_rd   <= 1'b1;
              state   <= S_RD_POLY;
            end
          end
        end
        S_RD_POLY: state <= S_WT_POLY;
        S_WT_POLY: begin
          ud_a  <= pr_data;
          ud_h  <= mask;
          state <= S_WR_POLY;
        end
        S_WR_POLY: begin
          // ud_b has settled from the ud_a/ud_h registers loaded last cycle.
          pw_addr  <= PA_W'(k);
          pw_data  <= ud_b;
          pw_en    <= 1'b1;
          prev_end <= cnt_end;
          k        <= k_inc;
          if (k_inc == K_B) begin
            j <= cnt_end;
            if (cnt_end != OMEGA_B) begin
              hb_addr <= cnt_end;
              hb_rd   <= 1'b1;
            end
            state <= S_RD_PAD;
          end else begin
            hb_addr <= OMEGA_B + 8'(k_inc);
            hb_rd   <= 1'b1;
            state   <= S_RD_CNT;
          end
        end
        S_RD_PAD: begin
          if (j == OMEGA_B) state <= S_FIN;
          else              state <= S_WT_PAD;
        end
        S_WT_PAD: begin
          // Unused index slots must be zero for the encoding to be canonical.
          if (hb_data != 8'd0) begin
            state <= S_ABORT;
          end else begin
            j <= j_inc;
            if (j_inc != OMEGA_B) begin
              hb_addr <= j_inc;
              hb_rd   <= 1'b1;
            end
            state <= S_RD_PAD;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ABORT: begin
          done  <= 1'b1;
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polyvec_use_hint_ctrl.sv
// Purpose : directed bench for polyvec_use_hint_ctrl with hint/poly memory models,
//           a stand-in use_hint datapath and a write scoreboard.
// Latency : checks start-to-done cycle counts against the closed-form latency.
// Backpressure: none modelled; memories respond one cycle after each read strobe.
module tb_polyvec_use_hint_ctrl;

  localparam int K     = 4;
  localparam int OMEGA = 80;
  localparam int PA_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, err;
  logic [7:0]        hb_addr;
  logic              hb_rd;
  logic [7:0]        hb_data = '0;
  logic [PA_W-1:0]   pr_addr;
  logic              pr_rd;
  logic [8191:0]     pr_data = '0;
  logic [PA_W-1:0]   pw_addr;
  logic              pw_en;
  logic [8191:0]     pw_data;
  logic [8191:0]     ud_a;
  logic [255:0]      ud_h;
  logic [8191:0]     ud_b;

  polyvec_use_hint_ctrl #(.K(K), .OMEGA(OMEGA), .PA_W(PA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .hb_addr(hb_addr), .hb_rd(hb_rd), .hb_data(hb_data),
    .pr_addr(pr_addr), .pr_rd(pr_rd), .pr_data(pr_data),
    .pw_addr(pw_addr), .pw_en(pw_en), .pw_data(pw_data),
    .ud_a(ud_a), .ud_h(ud_h), .ud_b(ud_b)
  );

  always #5 clk = ~clk;

  logic [7:0]    hb_mem [256];
  logic [8191:0] pr_mem [8];

  always @(posedge clk) begin
    if (hb_rd) hb_data <= hb_mem[hb_addr];
    if (pr_rd) pr_data <= pr_mem[pr_addr];
  end

  // Stand-in datapath: flipped lane where the hint bit is set, incremented otherwise.
  always_comb begin
    ud_b = '0;
    for (int i = 0; i < 256; i++)
      ud_b[32*i +: 32] = ud_h[i] ? ~ud_a[32*i +: 32] : ud_a[32*i +: 32] + 32'd1;
  end

  function automatic logic [8191:0] exp_poly(input int kk, input logic [255:0] m);
    logic [8191:0] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      r[32*i +: 32] = m[i] ? ~pr_mem[kk][32*i +: 32] : pr_mem[kk][32*i +: 32] + 32'd1;
    return r;
  endfunction

  typedef struct {
    logic [PA_W-1:0] a;
    logic [8191:0]   d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  wr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input int kk, input logic [255:0] m);
    wr_t w;
    w.a = PA_W'(kk);
    w.d = exp_poly(kk, m);
    sb.push_back(w);
  endtask

  task automatic clear_hb();
    for (int i = 0; i < 256; i++) hb_mem[i] = 8'd0;
  endtask

  // Write monitor: every pw_en pulse is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && pw_en) begin
      wr_t w;
      int  lane;
      wr_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL wr_unexpected observed_addr=%0d expected=no_write", pw_addr);
      end
      if (sb.size() != 0) begin
        w = sb.pop_front();
        checks++;
        assert (pw_addr === w.a) else begin
          failures++;
          $error("FAIL wr_addr observed=%0d expected=%0d", pw_addr, w.a);
        end
        checks++;
        assert (pw_data === w.d) else begin
          failures++;
          lane = 0;
          for (int i = 255; i >= 0; i--)
            if (pw_data[32*i +: 32] !== w.d[32*i +: 32]) lane = i;
          $error("FAIL wr_data k=%0d lane=%0d observed=%h expected=%h",
                 w.a, lane, pw_data[32*lane +: 32], w.d[32*lane +: 32]);
        end
      end
    end
  end

  // One operation: pulse start, count edges (the start-sampling edge is 1)
  // until done, then check outcome. extra_at re-pulses start while busy.
  task automatic run_op(input string tag, input int exp_cyc, input logic exp_err,
                        input int exp_wr, input int extra_at);
    int cyc;
    wr_cnt = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    while (cyc < 5000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      start = (cyc == extra_at);
      if (done) break;
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_err_held"}, 32'(err), 32'(exp_err));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  logic [255:0] m;

  initial begin
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < 256; i++)
        pr_mem[p][32*i +: 32] = $urandom;
    clear_hb();

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_hb_rd", 32'(hb_rd), 0);
    chk("rst_pr_rd", 32'(pr_rd), 0);
    chk("rst_pw_en", 32'(pw_en), 0);
    chk("rst_hb_addr", 32'(hb_addr), 0);
    chk("rst_ud_a", 32'(|ud_a), 0);
    chk("rst_ud_h", 32'(|ud_h), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All-zero hint field: four writes with empty masks, full pad scan.
    clear_hb();
    for (int kk = 0; kk < 4; kk++) push_wr(kk, '0);
    run_op("zero", 183, 1'b0, 4, 0);

    // Mixed counts {2,2,5,5}, including lane 255 and an empty polynomial.
    clear_hb();
    hb_mem[80] = 2; hb_mem[81] = 2; hb_mem[82] = 5; hb_mem[83] = 5;
    hb_mem[0] = 3; hb_mem[1] = 200; hb_mem[2] = 0; hb_mem[3] = 17; hb_mem[4] = 255;
    m = '0; m[3] = 1'b1; m[200] = 1'b1; push_wr(0, m);
    push_wr(1, '0);
    m = '0; m[0] = 1'b1; m[17] = 1'b1; m[255] = 1'b1; push_wr(2, m);
    push_wr(3, '0);
    run_op("mixed", 183, 1'b0, 4, 0);

    // Duplicate index inside polynomial 0.
    clear_hb();
    hb_mem[80] = 2; hb_mem[81] = 2; hb_mem[82] = 2; hb_mem[83] = 2;
    hb_mem[0] = 9; hb_mem[1] = 9;
    run_op("dup", 8, 1'b1, 0, 0);

    // Decreasing cumulative count at k=1: only polynomial 0 written.
    clear_hb();
    hb_mem[80] = 3; hb_mem[81] = 2; hb_mem[82] = 3; hb_mem[83] = 3;
    hb_mem[0] = 1; hb_mem[1] = 2; hb_mem[2] = 3;
    m = '0; m[1] = 1'b1; m[2] = 1'b1; m[3] = 1'b1; push_wr(0, m);
    run_op("decr", 15, 1'b1, 1, 0);

    // Count byte above OMEGA.
    clear_hb();
    hb_mem[80] = 81;
    run_op("over", 4, 1'b1, 0, 0);

    // Valid counts, index order restarting per poly, nonzero pad byte 70.
    clear_hb();
    hb_mem[80] = 1; hb_mem[81] = 3; hb_mem[82] = 4; hb_mem[83] = 5;
    hb_mem[0] = 10; hb_mem[1] = 5; hb_mem[2] = 6; hb_mem[3] = 250; hb_mem[4] = 100;
    hb_mem[70] = 8'h01;
    m = '0; m[10] = 1'b1; push_wr(0, m);
    m = '0; m[5] = 1'b1; m[6] = 1'b1; push_wr(1, m);
    m = '0; m[250] = 1'b1; push_wr(2, m);
    m = '0; m[100] = 1'b1; push_wr(3, m);
    run_op("pad", 164, 1'b1, 4, 0);

    // end == OMEGA: all 80 hints on polynomial 3, empty pad scan.
    clear_hb();
    hb_mem[80] = 0; hb_mem[81] = 0; hb_mem[82] = 0; hb_mem[83] = 80;
    m = '0;
    for (int i = 0; i < 80; i++) begin
      hb_mem[i] = 8'(3 * i);
      m[3 * i] = 1'b1;
    end
    push_wr(0, '0); push_wr(1, '0); push_wr(2, '0); push_wr(3, m);
    run_op("full", 183, 1'b0, 4, 0);

    // Reset during WT_IDX of k=1 (11th state after start).
    clear_hb();
    hb_mem[80] = 1; hb_mem[81] = 3; hb_mem[82] = 3; hb_mem[83] = 3;
    hb_mem[0] = 4; hb_mem[1] = 5; hb_mem[2] = 6;
    m = '0; m[4] = 1'b1; push_wr(0, m);
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_pre_busy", 32'(busy), 1);
    chk("midrst_pre_writes", 32'(wr_cnt), 1);
    chk("midrst_pre_hb_addr", 32'(hb_addr), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_hb_addr", 32'(hb_addr), 0);
    chk("midrst_pw_en", 32'(pw_en), 0);
    chk("midrst_ud_h", 32'(|ud_h), 0);
    chk("midrst_sb_left", 32'(sb.size()), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Clean run after reset, with a stray start pulse while busy.
    clear_hb();
    for (int kk = 0; kk < 4; kk++) push_wr(kk, '0);
    run_op("after_rst", 183, 1'b0, 4, 50);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/polyvec_use_hint_ctrl.md
Name: polyvec_use_hint_ctrl

Overview:
- Sequences the combinational 256-lane use_hint datapath over the K polynomials of w'approx during signature verification.
- Decodes the packed signature hint field (OMEGA index bytes followed by K cumulative-count bytes) into one 256-bit hint mask per polynomial, and flags malformed encodings.
- Fetches each polynomial, drives the datapath with it and its mask, and writes the corrected w1 polynomial back to memory.
- Sits between the verify top-level FSM, the hint byte buffer, the polynomial RAM and the poly_use_hint instance.

Parameters:
K, 4, number of polynomials in the vector (4/6/8); K <= 8
OMEGA, 80, max total hints (80/55/75); OMEGA+K <= 256
PA_W, 3, polynomial RAM address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at completion or abort
err  out  1  malformed hint encoding; valid with done, held until next start
hb_addr  out  8  hint byte read address
hb_rd  out  1  hint byte read strobe; data on hb_data next cycle
hb_data  in  8  hint byte read data
pr_addr  out  PA_W  polynomial read address (k)
pr_rd  out  1  poly read strobe; data on pr_data next cycle
pr_data  in  8192  256 x 32-bit coefficients, coeff i at [32i+31:32i]
pw_addr  out  PA_W  polynomial write address (k)
pw_en  out  1  poly write strobe
pw_data  out  8192  corrected polynomial
ud_a  out  8192  to datapath a_in
ud_h  out  256  to datapath h_in
ud_b  in  8192  from datapath b_out, combinational from ud_a/ud_h

Behaviour:
- Reset, asynchronous: state IDLE. busy, done, err, hb_rd, pr_rd and pw_en are 0. All addresses, ud_a, ud_h, the hint mask, k, j, prev_end and prev_idx are 0.
- All outputs are registered. Memory reads have a fixed 1-cycle latency. Each read is an issue state followed by a wait state.
- Start handling:
  - start in IDLE: clear err, k=0, prev_end=0, go to RD_CNT.
  - start while busy is ignored.
- RD_CNT: hb_addr=OMEGA+k, hb_rd=1.
- WT_CNT: end=hb_data. If end<prev_end or end>OMEGA, go to ABORT. Otherwise clear mask, j=prev_end. Go to RD_IDX if j<end, else RD_POLY.
- RD_IDX: hb_addr=j, hb_rd=1.
- WT_IDX: idx=hb_data.
  - If j>prev_end and idx<=prev_idx, go to ABORT.
  - Else set mask[idx], prev_idx=idx, j++.
  - Loop to RD_IDX while j<end, else go to RD_POLY.
- RD_POLY: pr_addr=k, pr_rd=1.
- WT_POLY: ud_a=pr_data, ud_h=mask.
- WR_POLY: pw_addr=k, pw_data=ud_b, pw_en=1. prev_end=end, k++.
  - If k==K, go to RD_PAD with j=prev_end.
  - Else go to RD_CNT.
- Pad check:
  - RD_PAD: if j==OMEGA, go to FIN; else hb_addr=j, hb_rd=1.
  - WT_PAD: any nonzero hb_data goes to ABORT; else j++ and return to RD_PAD.
- FIN: done=1, err=0, go to IDLE.
- ABORT: done=1, err=1, go to IDLE. No further pw_en is issued. Polynomials already written remain in RAM, and the consumer discards them on err.
- Latency, start to done, error-free: 1 + sum over k of (5 + 2*n_k) + 2*(OMEGA-total) + 1 + 1 cycles, where n_k is the number of hints in poly k and total is the sum of n_k.
- Duplicate index within a poly: rejected by the strictly increasing index check.
- Zero hints for a poly: the mask is all zeros and the datapath still runs.
- end==OMEGA: the pad check is empty.
- Index ordering resets at each poly boundary: the first index of a poly is not compared with the previous poly's indices.
- Reset asserted mid-operation: immediate return to IDLE. Any in-flight write is dropped; pw_en falls asynchronously.

Test Plan:
- K=4, OMEGA=80, all count bytes 0, all index bytes 0 -> 4 writes k=0..3, each pw_data equal to datapath output with h=0, done after 1+4*5+160+2=183 cycles, err=0.
- Counts {2,2,5,5}, indices [3,200 | — | 0,17,255 | —], rest 0 -> masks {bit3,bit200}, 0, {0,17,255}, 0. 4 writes, err=0.
- Counts {2,...} with indices 9,9 -> ABORT after the second WT_IDX, done=1, err=1, zero pw_en pulses.
- Counts {3,2,...} (decreasing) -> ABORT in WT_CNT for k=1, exactly one write (k=0), err=1.
- Count byte 81 (>OMEGA) at k=0 -> abort, no writes. Separately, valid counts with total 5 and byte 70 = 0x01 -> all 4 writes, then err=1 at the pad check.
- Reset pulsed during WT_IDX of k=1 -> outputs zero at once. A new start then completes a clean run with err=0, and start pulses while busy are ignored.
